// File: rtl/mul_accum_pkg.sv
// Shared types, ASCII constants and helpers for the mul(X,Y) stream parser.
package aoc_d3_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_M,
        S_U,
        S_L,
        S_X,
        S_Y
    } mul_state_t;

    localparam logic [7:0] CH_M     = 8'h6D;
    localparam logic [7:0] CH_U     = 8'h75;
    localparam logic [7:0] CH_L     = 8'h6C;
    localparam logic [7:0] CH_LPAR  = 8'h28;
    localparam logic [7:0] CH_COMMA = 8'h2C;
    localparam logic [7:0] CH_RPAR  = 8'h29;
    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_9     = 8'h39;

    localparam logic [31:0] MUL_PHRASE = {CH_M, CH_U, CH_L, CH_LPAR};

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= CH_0) && (c <= CH_9);
    endfunction

    // Byte idx of "mul(", idx 0 being 'm'.
    function automatic logic [7:0] phrase_char(input logic [1:0] idx);
        return MUL_PHRASE[8*(3-idx) +: 8];
    endfunction

    function automatic int op_width(input int max_digits);
        return $clog2(10**max_digits);
    endfunction

endpackage

// File: rtl/mul_accum_if.sv
// Byte-stream input and sum/status output bundle of the mul(X,Y) accumulator.
interface mul_accum_if #(
    parameter int SUM_W = 32
);
    logic [7:0]       read_val;
    logic             en;
    logic             last;
    logic             do_det;
    logic             dont_det;
    logic [SUM_W-1:0] sum;
    logic             mul_ok;
    logic             done;

    modport master (
        output read_val, en, last, do_det, dont_det,
        input  sum, mul_ok, done
    );

    modport slave (
        input  read_val, en, last, do_det, dont_det,
        output sum, mul_ok, done
    );
endinterface

// File: rtl/mul_accum_operand_acc.sv
// Decimal operand accumulator: value = value*10 + digit, with a digit count
// and an overflow flag raised when a digit arrives with the count already full.
module operand_acc
    import aoc_d3_pkg::*;
#(
    parameter int MAX_DIGITS = 3,
    parameter int OP_W       = 10,
    parameter int CNT_W      = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             dig_stb_i,
    input  logic [3:0]       dig_i,
    output logic [OP_W-1:0]  value_o,
    output logic [CNT_W-1:0] count_o,
    output logic             ovf_o
);
    logic [OP_W-1:0]  value_q, value_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full;

    assign full  = (count_q == CNT_W'(MAX_DIGITS));
    assign ovf_o = dig_stb_i && full;

    always_comb begin
        value_d = value_q;
        count_d = count_q;
        if (clear_i) begin
            value_d = '0;
            count_d = '0;
        end else if (dig_stb_i && !full) begin
            value_d = value_q * OP_W'(10) + OP_W'(dig_i);
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= '0;
            count_q <= '0;
        end else begin
            value_q <= value_d;
            count_q <= count_d;
        end
    end

    assign value_o = value_q;
    assign count_o = count_q;
endmodule

// File: rtl/mul_accum.sv
// Parses mul(X,Y) out of an ASCII stream and accumulates X*Y into a wrapping sum.
// Define MUL_DO_GATE_EN to gate accumulation with the do()/don't() detector pulses.
module mul_accum
    import aoc_d3_pkg::*;
#(
    parameter int SUM_W      = 32,
    parameter int MAX_DIGITS = 3
) (
    input logic        clk,
    input logic        rst,
    mul_accum_if.slave bus
);
    localparam int OP_W   = op_width(MAX_DIGITS);
    localparam int CNT_W  = $clog2(MAX_DIGITS + 1);
    localparam int PROD_W = 2 * OP_W;

    mul_state_t       state_q, state_d;
    logic [SUM_W-1:0] sum_q, sum_d;
    logic             mul_ok_q, mul_ok_d;
    logic             done_q, done_d;
    logic             enabled_d;

    logic             active;
    logic [3:0]       dig;
    logic             op_clear, x_stb, y_stb, x_ovf, y_ovf;
    logic [OP_W-1:0]  x_val, y_val;
    logic [CNT_W-1:0] x_cnt, y_cnt;
    logic [PROD_W-1:0] prod;
    mul_state_t       resync;

    assign active   = bus.en && !done_q;
    assign dig      = 4'(bus.read_val - CH_0);
    assign op_clear = active && (state_q == S_L) && (bus.read_val == CH_LPAR);
    assign x_stb    = active && (state_q == S_X) && is_digit(bus.read_val);
    assign y_stb    = active && (state_q == S_Y) && is_digit(bus.read_val);
    assign prod     = PROD_W'(x_val) * PROD_W'(y_val);
    // An unexpected 'm' may itself start a new instruction.
    assign resync   = (bus.read_val == CH_M) ? S_M : S_IDLE;

    operand_acc #(.MAX_DIGITS(MAX_DIGITS), .OP_W(OP_W), .CNT_W(CNT_W)) u_x (
        .clk(clk), .rst(rst), .clear_i(op_clear), .dig_stb_i(x_stb), .dig_i(dig),
        .value_o(x_val), .count_o(x_cnt), .ovf_o(x_ovf)
    );

    operand_acc #(.MAX_DIGITS(MAX_DIGITS), .OP_W(OP_W), .CNT_W(CNT_W)) u_y (
        .clk(clk), .rst(rst), .clear_i(op_clear), .dig_stb_i(y_stb), .dig_i(dig),
        .value_o(y_val), .count_o(y_cnt), .ovf_o(y_ovf)
    );

`ifdef MUL_DO_GATE_EN
    logic enabled_q;

    // Detector pulses land on the same en cycle as a ')' and must apply first.
    always_comb begin
        enabled_d = enabled_q;
        if (active) begin
            if (bus.dont_det)    enabled_d = 1'b0;
            else if (bus.do_det) enabled_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) enabled_q <= 1'b1;
        else     enabled_q <= enabled_d;
    end
`else
    logic unused_det;
    assign unused_det = bus.do_det ^ bus.dont_det;
    assign enabled_d  = 1'b1;
`endif

    always_comb begin
        state_d  = state_q;
        sum_d    = sum_q;
        mul_ok_d = 1'b0;
        done_d   = done_q;
        if (active) begin
            if (bus.last) done_d = 1'b1;
            state_d = resync;
            unique case (state_q)
                S_IDLE: if (bus.read_val == phrase_char(2'd0)) state_d = S_M;
                S_M:    if (bus.read_val == phrase_char(2'd1)) state_d = S_U;
                S_U:    if (bus.read_val == phrase_char(2'd2)) state_d = S_L;
                S_L:    if (bus.read_val == phrase_char(2'd3)) state_d = S_X;
                S_X: begin
                    if (x_stb && !x_ovf)
                        state_d = S_X;
                    else if (bus.read_val == CH_COMMA && x_cnt != '0)
                        state_d = S_Y;
                end
                S_Y: begin
                    if (y_stb && !y_ovf) begin
                        state_d = S_Y;
                    end else if (bus.read_val == CH_RPAR && y_cnt != '0) begin
                        state_d = S_IDLE;
                        if (enabled_d) begin
                            sum_d    = sum_q + SUM_W'(prod);
                            mul_ok_d = 1'b1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            sum_q    <= '0;
            mul_ok_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sum_q    <= sum_d;
            mul_ok_q <= mul_ok_d;
            done_q   <= done_d;
        end
    end

    assign bus.sum    = sum_q;
    assign bus.mul_ok = mul_ok_q;
    assign bus.done   = done_q;
endmodule

// File: tb/tb_mul_accum.sv
// Scoreboard bench for mul_accum: a 32-bit and an 8-bit sum instance share one stimulus stream.
module tb_mul_accum;
    import aoc_d3_pkg::*;

    typedef byte unsigned bq_t[$];

`ifdef MUL_DO_GATE_EN
    localparam bit GATE = 1'b1;
`else
    localparam bit GATE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rv;
    logic       en, last, dd, dn;

    always #5 clk = ~clk;

    mul_accum_if #(.SUM_W(32)) bus32 ();
    mul_accum_if #(.SUM_W(8))  bus8 ();

    assign bus32.read_val = rv;
    assign bus32.en       = en;
    assign bus32.last     = last;
    assign bus32.do_det   = dd;
    assign bus32.dont_det = dn;
    assign bus8.read_val  = rv;
    assign bus8.en        = en;
    assign bus8.last      = last;
    assign bus8.do_det    = dd;
    assign bus8.dont_det  = dn;

    mul_accum #(.SUM_W(32), .MAX_DIGITS(3)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
    mul_accum #(.SUM_W(8),  .MAX_DIGITS(3)) dut8  (.clk(clk), .rst(rst), .bus(bus8));

    int total = 0;
    int bad   = 0;

    logic [31:0] q32[$];
    logic [7:0]  q8[$];
    int          pulses32 = 0;
    bit          done_at_pulse32 = 1'b0;

    // Everything accepted (en=1) since the last reset.
    byte unsigned h_b[$];
    bit           h_do[$];
    bit           h_dont[$];
    bit           h_last[$];

    // Monitor: every mul_ok pulse pops one expected running sum.
    always @(negedge clk) begin : monitor
        logic [31:0] e32;
        logic [7:0]  e8;
        if (rst === 1'b0) begin
            if (bus32.mul_ok === 1'b1) begin
                total++;
                pulses32++;
                done_at_pulse32 = bus32.done;
                if (q32.size() == 0) begin
                    bad++;
                    $display("FAIL mon32 unexpected mul_ok actual_sum=%0d required=no pulse", bus32.sum);
                end else begin
                    e32 = q32.pop_front();
                    if (bus32.sum !== e32) begin
                        bad++;
                        $display("FAIL mon32 sum actual=%0d required=%0d", bus32.sum, e32);
                    end
                end
            end
            if (bus8.mul_ok === 1'b1) begin
                total++;
                if (q8.size() == 0) begin
                    bad++;
                    $display("FAIL mon8 unexpected mul_ok actual_sum=%0d required=no pulse", bus8.sum);
                end else begin
                    e8 = q8.pop_front();
                    if (bus8.sum !== e8) begin
                        bad++;
                        $display("FAIL mon8 sum actual=%0d required=%0d", bus8.sum, e8);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic bq_t str2q(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    function automatic bit ends_with(input bq_t s, input int k, input string pat);
        int l = pat.len();
        if (k - l + 1 < 0) return 1'b0;
        for (int i = 0; i < l; i++)
            if (s[k-l+1+i] != pat[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit dig(input byte unsigned c);
        return (c >= 8'h30) && (c <= 8'h39);
    endfunction

    // Does a complete mul(X,Y) with 1..3 digit operands begin at p and end by stop?
    function automatic bit match_at(input int p, input int stop, output int c,
                                    output logic [31:0] xv, output logic [31:0] yv);
        string ph = "mul(";
        int    q;
        int    nd;
        xv = 0; yv = 0; c = 0;
        if (p + 3 > stop) return 1'b0;
        for (int k = 0; k < 4; k++)
            if (h_b[p+k] != ph[k]) return 1'b0;
        q = p + 4; nd = 0;
        while (q <= stop && dig(h_b[q])) begin
            xv = xv * 10 + 32'(h_b[q] - 8'h30);
            nd++; q++;
        end
        if (nd < 1 || nd > 3 || q > stop || h_b[q] != 8'h2C) return 1'b0;
        q++; nd = 0;
        while (q <= stop && dig(h_b[q])) begin
            yv = yv * 10 + 32'(h_b[q] - 8'h30);
            nd++; q++;
        end
        if (nd < 1 || nd > 3 || q > stop || h_b[q] != 8'h29) return 1'b0;
        c = q;
        return 1'b1;
    endfunction

    // Rescan the whole history; queue expectations for commits at index >= new_from.
    task automatic run_model(input int new_from, output logic [31:0] sum_out, output bit fin);
        int   n    = h_b.size();
        int   stop = n - 1;
        int   p    = 0;
        int   c;
        bit   e    = 1'b1;
        bit   en_at[];
        logic [31:0] xv, yv;
        fin = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (h_last[k]) begin
                stop = k;
                fin  = 1'b1;
                break;
            end
        end
        en_at = new[n];
        for (int k = 0; k < n; k++) begin
            if (GATE) begin
                if (h_dont[k])    e = 1'b0;
                else if (h_do[k]) e = 1'b1;
            end
            en_at[k] = e;
        end
        sum_out = 0;
        while (p <= stop) begin
            if (match_at(p, stop, c, xv, yv)) begin
                if (en_at[c]) begin
                    sum_out = sum_out + xv * yv;
                    if (c >= new_from) begin
                        q32.push_back(sum_out);
                        q8.push_back(sum_out[7:0]);
                    end
                end
                p = c + 1;
            end else begin
                p++;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; rv = 8'h00; en = 1'b0; last = 1'b0; dd = 1'b0; dn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        h_b.delete(); h_do.delete(); h_dont.delete(); h_last.delete();
        q32.delete(); q8.delete();
        @(negedge clk);
        check("reset sum32",  bus32.sum, 0);
        check("reset sum8",   32'(bus8.sum), 0);
        check("reset mul_ok", 32'(bus32.mul_ok), 0);
        check("reset done",   32'(bus32.done), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input string tag, input bq_t s, input bit last_end, input bit detect,
                        input bit rnd, input bit gaps, output logic [31:0] exp_sum);
        int  from = h_b.size();
        int  n    = s.size();
        bit  fin;
        bit  dof[];
        bit  dnf[];
        dof = new[n];
        dnf = new[n];
        for (int k = 0; k < n; k++) begin
            dof[k] = 1'b0;
            dnf[k] = 1'b0;
            // Detector emulation: pulse on the first byte after the closing ')'.
            if (detect && k >= 1) begin
                if (ends_with(s, k - 1, "do()"))    dof[k] = 1'b1;
                if (ends_with(s, k - 1, "don't()")) dnf[k] = 1'b1;
            end
            if (rnd) begin
                if ($urandom_range(0, 15) == 0) dof[k] = 1'b1;
                if ($urandom_range(0, 15) == 0) dnf[k] = 1'b1;
            end
            h_b.push_back(s[k]);
            h_do.push_back(dof[k]);
            h_dont.push_back(dnf[k]);
            h_last.push_back(last_end && (k == n - 1));
        end
        run_model(from, exp_sum, fin);
        for (int k = 0; k < n; k++) begin
            rv = s[k]; en = 1'b1; last = last_end && (k == n - 1); dd = dof[k]; dn = dnf[k];
            @(posedge clk);
            #1;
            if (gaps) begin
                rv = 8'($urandom); en = 1'b0;
                last = 1'($urandom); dd = 1'($urandom); dn = 1'($urandom);
                @(posedge clk);
                #1;
            end
        end
        en = 1'b0; last = 1'b0; dd = 1'b0; dn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check({tag, " pending32"}, 32'(q32.size()), 0);
        check({tag, " pending8"},  32'(q8.size()), 0);
        check({tag, " sum32"},     bus32.sum, exp_sum);
        check({tag, " sum8"},      32'(bus8.sum), 32'(exp_sum[7:0]));
        check({tag, " done"},      32'(bus32.done), 32'(fin));
        check({tag, " done8"},     32'(bus8.done), 32'(fin));
        $display("stream %s bytes=%0d sum32=%0d sum8=%0d done=%0b", tag, n, bus32.sum, bus8.sum, bus32.done);
    endtask

    string toks[] = '{"mul(", "mul(", "mul(", "m", "mu", "1", "23", "456", "7890", ",", ",",
                      ")", ")", "(", "x", "do()", "don't()", "mul(3,4)", "mul(12,34)",
                      "mul(999,1)", "]", " "};

    initial begin
        logic [31:0] es;
        int          p0;
        bq_t         rq;
        string       t;

        do_reset();

        // Single instruction with last on ')': pulse, sum and done together.
        p0 = pulses32;
        send("t1", str2q("mul(2,4)"), 1'b1, 1'b0, 1'b0, 1'b0, es);
        check("t1 const sum", bus32.sum, 8);
        check("t1 pulses", 32'(pulses32 - p0), 1);
        check("t1 done at pulse", 32'(done_at_pulse32), 1);
        send("t6 sticky", str2q("mul(1,1)"), 1'b0, 1'b0, 1'b0, 1'b0, es);
        check("t6 sticky const", bus32.sum, 8);

        do_reset();
        p0 = pulses32;
        send("t2", str2q("xmul(2,4)%&mul[3,7]!@^do_not_mul(5,5)+mul(32,64]then(mul(11,8)mul(8,5))"),
             1'b0, 1'b0, 1'b0, 1'b0, es);
        check("t2 const sum", bus32.sum, 161);
        check("t2 pulses", 32'(pulses32 - p0), 4);

        do_reset();
        send("t3", str2q("xmul(2,4)&mul[3,7]!^don't()_mul(5,5)+mul(32,64](mul(11,8)undo()?mul(8,5))"),
             1'b0, 1'b1, 1'b0, 1'b0, es);
        check("t3 const sum", bus32.sum, GATE ? 32'd48 : 32'd161);

        do_reset();
        p0 = pulses32;
        send("t4 bad", str2q("mul(1234,5)mul(,5)mul(4,)"), 1'b0, 1'b0, 1'b0, 1'b0, es);
        check("t4 bad const", bus32.sum, 0);
        check("t4 bad pulses", 32'(pulses32 - p0), 0);
        send("t4 max", str2q("mul(999,999)"), 1'b0, 1'b0, 1'b0, 1'b0, es);
        check("t4 max const", bus32.sum, 998001);

        do_reset();
        send("t5 resync", str2q("mmul(3,3)"), 1'b0, 1'b0, 1'b0, 1'b1, es);
        check("t5 resync const", bus32.sum, 9);
        do_reset();
        send("t5 wrap", str2q("mul(16,17)"), 1'b0, 1'b0, 1'b0, 1'b0, es);
        check("t5 wrap8 const", 32'(bus8.sum), 16);
        check("t5 wrap32 const", bus32.sum, 272);

        do_reset();
        send("t6 pre", str2q("mul(12,"), 1'b0, 1'b0, 1'b0, 1'b0, es);
        do_reset();
        p0 = pulses32;
        send("t6 post", str2q("3)"), 1'b0, 1'b0, 1'b0, 1'b0, es);
        check("t6 post const", bus32.sum, 0);
        check("t6 post pulses", 32'(pulses32 - p0), 0);

        // Randomized streams, each in two chunks so partial parses cross chunk boundaries.
        for (int r = 0; r < 10; r++) begin
            do_reset();
            for (int ch = 0; ch < 2; ch++) begin
                rq.delete();
                for (int k = 0; k < 25; k++) begin
                    if ($urandom_range(0, 19) == 0) begin
                        rq.push_back(8'(8'h80 + $urandom_range(0, 127)));
                    end else begin
                        t = toks[$urandom_range(0, toks.size() - 1)];
                        for (int i = 0; i < t.len(); i++) rq.push_back(t[i]);
                    end
                end
                send($sformatf("rnd%0d.%0d", r, ch), rq, ($urandom_range(0, 3) == 0),
                     1'b1, 1'b1, 1'($urandom), es);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mul_accum.md
Name: mul_accum

Overview:
- Downstream consumer of the byte stream and do/don't detector pulses in the day-3 pipeline.
- Parses `mul(X,Y)` instructions out of the raw ASCII stream, where X and Y are 1 to MAX_DIGITS decimal digits.
- Multiplies X by Y and adds the product to a running sum, gated by the enable state from the do()/don't() detectors.
- Feeds the final sum to the result/readout stage.

Parameters:
- SUM_W, 32: accumulator width; the sum wraps modulo 2^SUM_W.
- MAX_DIGITS, 3: maximum digits per operand. Operand register width is derived: ceil(log2(10^MAX_DIGITS)).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- read_val  input  8  ASCII byte from the stream
- en  input  1  read_val valid this cycle; all parsing advances only when en=1
- last  input  1  qualifies the final byte of the stream; sampled only when en=1
- do_det  input  1  do() detector output; sampled only when en=1
- dont_det  input  1  don't() detector output; sampled only when en=1
- sum  output  SUM_W  running accumulated total
- mul_ok  output  1  one-cycle pulse on each committed product
- done  output  1  sticky; stream finished and sum is final

Behaviour:
- Reset (async, rst=1): sum=0, mul_ok=0, done=0, enabled=1, state=S_IDLE, operands and digit counts cleared. Reset mid-instruction discards the partial parse.
- FSM states, evaluated on en=1 cycles only:
  - S_IDLE: 'm' -> S_M
  - S_M: 'u' -> S_U
  - S_U: 'l' -> S_L
  - S_L: '(' -> S_X. Clear X, Y and both digit counts.
  - S_X: digit -> X=X*10+d and xcnt++. If xcnt is already MAX_DIGITS, a further digit aborts. ',' with xcnt>=1 -> S_Y.
  - S_Y: digit handling as in S_X, applied to Y. ')' with ycnt>=1 -> commit, then S_IDLE.
- Abort and resync: any unexpected byte in any state returns to S_IDLE. If that byte is 'm', go to S_M instead. Example: "mmul(" parses.
- Commit:
  - The product X*Y is computed at full width: 2 × operand width.
  - sum <= sum + product when enabled=1; the addition wraps modulo 2^SUM_W.
  - sum and mul_ok update on the clock edge that accepts the ')' byte, so they are visible the cycle after ')'.
  - mul_ok pulses only when the product is actually added.
- Enable tracking (en=1 cycles only):
  - dont_det=1 -> enabled<=0.
  - else do_det=1 -> enabled<=1.
  - Both high -> dont wins.
  - A do/dont sampled on the same en cycle as a ')' byte applies before that commit. This matches the one-cycle detector latency: the pulse appears on the first en cycle after the detector's closing ')'.
- Bytes with en=0: state, operands, enabled and done all hold; mul_ok=0.
- last=1 with en=1: the byte is processed normally, including any commit. done<=1 on the same edge, so done and the final sum are visible together. Once done=1, further en cycles are ignored until reset.
- Non-ASCII bytes (>=0x80) are treated as unexpected characters.

Optional Feature:
- Macro: MUL_DO_GATE_EN.
- Defined: enable gating as above (part 2 semantics).
- Undefined: do_det and dont_det are ignored, enabled is constant 1, and every valid mul is accumulated (part 1 semantics). The ports remain present.

Decomposition:
- Package aoc_d3_pkg holds:
  - the state enum mul_state_t
  - ASCII constants CH_M, CH_U, CH_L, CH_LPAR, CH_COMMA, CH_RPAR, CH_0, CH_9
  - the "mul(" phrase constant
  - an is_digit function
- Sub-module operand_acc, instantiated twice for X and Y:
  - inputs: clear, digit strobe and digit value
  - outputs: value, count, overflow flag (set when count would exceed MAX_DIGITS)

Test Plan:
1. Stream "mul(2,4)", with last on ')' -> mul_ok pulses once the cycle after ')'; sum=8; done=1 on that same cycle.
2. Stream "xmul(2,4)%&mul[3,7]!@^do_not_mul(5,5)+mul(32,64]then(mul(11,8)mul(8,5))", detectors idle -> sum=161; mul_ok pulses 4 times.
3. Stream "xmul(2,4)&mul[3,7]!^don't()_mul(5,5)+mul(32,64](mul(11,8)undo()?mul(8,5))", driving do_det/dont_det with one-cycle latency -> sum=48 with MUL_DO_GATE_EN; sum=161 without.
4. Operand digit limits:
   - "mul(1234,5)", "mul(,5)" and "mul(4,)" -> sum=0, no mul_ok.
   - "mul(999,999)" -> sum=998001.
5. Resync and idle gaps: "mmul(3,3)" with en toggling 1,0,1 between every byte -> sum=9. With SUM_W=8, "mul(16,17)" -> sum=16 (272 mod 256).
6. Reset and sticky done:
   - rst asserted after "mul(12,", then "3)" streamed -> sum=0, no mul_ok.
   - After done=1, streaming "mul(1,1)" leaves sum unchanged.
